// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with 16x oversampling feeding a first-word fall-through FIFO.
// Runs entirely on the board clock; bytes leave over a valid/ready pop interface.
module uart_rx_fifo #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 115200,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DATA_W = 8;
  localparam int DIV    = CLK_FREQUENCY / (BAUD_RATE * 16);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_p0, rx_s;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [3:0]          os_cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shift_p;
  logic                push, stop_bad, sample_bit;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, pop, wr_en;

  // Stage p0/p1: two-flop synchroniser, idles high out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= uart_rx;
      rx_s       <= rx_meta_p0;
    end
  end

  // Held at zero while idle so the first tick lands DIV cycles after the start edge
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (state_q == S_IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: if (tick && os_cnt == 4'd7) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick && os_cnt == 4'd15 && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP:  if (tick && os_cnt == 4'd15) state_d = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    stop_bad   = 1'b0;
    sample_bit = 1'b0;
    case (state_q)
      S_DATA: sample_bit = tick && (os_cnt == 4'd15);
      S_STOP: begin
        push     = tick && (os_cnt == 4'd15) && rx_s;
        stop_bad = tick && (os_cnt == 4'd15) && !rx_s;
      end
      default: ;
    endcase
  end

  // Oversample count restarts on every state change; 16 ticks per bit wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt  <= '0;
      bit_idx <= '0;
    end else begin
      if (state_d != state_q) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_cnt + 4'd1;
      end
      if (state_q == S_START) begin
        bit_idx <= '0;
      end else if (sample_bit) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample_bit) begin
      shift_p <= {rx_s, shift_p[DATA_W-1:1]};
    end
  end

  // Stage p2: FIFO write/pop; a pop frees the slot a same-cycle push lands in
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = rd_valid && rd_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift_p;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      frame_err <= stop_bad;
      overrun   <= push && full && !pop;
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed line scenarios plus random bytes, scored against
// an in-order byte queue with a capacity-limited drop rule.
module tb_uart_rx_fifo;

  localparam int CLK_F    = 1600000;
  localparam int BAUD     = 10000;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       uart_rx;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQUENCY(CLK_F),
    .BAUD_RATE    (BAUD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed side: popped bytes and pulse counts, sampled mid-cycle
  logic [7:0] got_q[$];
  int   ferr_cnt = 0;
  int   ovr_cnt  = 0;
  int   rv_rise  = 0;
  int   cnt_max  = 0;
  logic rv_prev  = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun)   ovr_cnt  <= ovr_cnt + 1;
      if (rd_valid && !rv_prev) rv_rise <= rv_rise + 1;
      if (int'(fifo_count) > cnt_max) cnt_max <= int'(fifo_count);
    end
    rv_prev <= rd_valid;
  end

  // Reference side: bytes expected out in order, plus expected pulse totals
  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int chk_idx  = 0;
  bit rand_rdy = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pulse_rdy);
    uart_rx = 1'b0;
    wait_cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(BIT_CLKS);
    end
    uart_rx = stop_ok;
    if (pulse_rdy) begin
      // Stop bit is sampled 83 cycles into it: 2 sync + 1 state + 80 oversample
      wait_cyc(82);
      rd_ready = 1'b1;
      cyc();
      rd_ready = 1'b0;
      wait_cyc(BIT_CLKS - 83);
    end else begin
      wait_cyc(BIT_CLKS);
    end
    if (!stop_ok) wait_cyc(500);
    uart_rx = 1'b1;
    wait_cyc(20);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit pop_same);
    int occ;
    occ = exp_q.size() - got_q.size();
    if (occ < DEPTH || pop_same) exp_q.push_back(b);
    else exp_ovr++;
  endtask

  task automatic compare_new(input string tag);
    int n;
    check_val({tag, " bytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = chk_idx; i < n; i++) check_val({tag, " data"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk_idx = exp_q.size();
  endtask

  initial begin
    logic [7:0] b;
    reset_n  = 1'b0;
    uart_rx  = 1'b1;
    rd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst rd_valid", 32'(rd_valid), 0);
    check_val("rst rd_data", 32'(rd_data), 0);
    check_val("rst count", 32'(fifo_count), 0);
    check_val("rst frame_err", 32'(frame_err), 0);
    check_val("rst overrun", 32'(overrun), 0);
    reset_n  = 1'b1;
    rd_ready = 1'b1;
    wait_cyc(20);

    b = 8'hA5;
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b0);
    wait_cyc(10);
    compare_new("single");
    check_val("single rv_rise", 32'(rv_rise), 1);
    check_val("single cnt_max", 32'(cnt_max), 1);
    check_val("single count", 32'(fifo_count), 0);
    check_val("single ferr", 32'(ferr_cnt), 0);
    check_val("single ovr", 32'(ovr_cnt), 0);

    uart_rx = 1'b0;
    wait_cyc(40);
    uart_rx = 1'b1;
    wait_cyc(200);
    check_val("glitch nopush", 32'(got_q.size()), 32'(exp_q.size()));
    check_val("glitch ferr", 32'(ferr_cnt), 0);
    b = 8'h3C;
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b0);
    wait_cyc(10);
    compare_new("glitch");

    send_frame(8'h55, 1'b0, 1'b0);
    exp_ferr++;
    check_val("ferr nopush", 32'(got_q.size()), 32'(exp_q.size()));
    b = 8'h12;
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b0);
    wait_cyc(10);
    compare_new("ferr");
    check_val("ferr pulses", 32'(ferr_cnt), 32'(exp_ferr));

    rd_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_frame(8'(i), 1'b0);
    end
    check_val("ovr count", 32'(fifo_count), 32'(DEPTH));
    check_val("ovr pulses", 32'(ovr_cnt), 32'(exp_ovr));
    check_val("ovr rd_valid", 32'(rd_valid), 1);
    rd_ready = 1'b1;
    wait_cyc(20);
    compare_new("ovr");
    check_val("ovr drained", 32'(fifo_count), 0);

    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b, 1'b0);
    end
    check_val("fullpp pre count", 32'(fifo_count), 32'(DEPTH));
    send_frame(8'h77, 1'b1, 1'b1);
    model_frame(8'h77, 1'b1);
    check_val("fullpp count", 32'(fifo_count), 32'(DEPTH));
    check_val("fullpp ovr", 32'(ovr_cnt), 32'(exp_ovr));
    rd_ready = 1'b1;
    wait_cyc(20);
    compare_new("fullpp");

    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b, 1'b0);
    end
    check_val("rstmid queued", 32'(fifo_count), 3);
    uart_rx = 1'b0;
    wait_cyc(BIT_CLKS * 4 + BIT_CLKS / 2);
    reset_n = 1'b0;
    #1;
    check_val("rstmid rd_valid", 32'(rd_valid), 0);
    check_val("rstmid count", 32'(fifo_count), 0);
    check_val("rstmid rd_data", 32'(rd_data), 0);
    repeat (3) void'(exp_q.pop_back());
    uart_rx = 1'b1;
    wait_cyc(5);
    reset_n  = 1'b1;
    rd_ready = 1'b1;
    wait_cyc(BIT_CLKS);
    b = 8'hC3;
    send_frame(b, 1'b1, 1'b0);
    model_frame(b, 1'b0);
    wait_cyc(10);
    compare_new("rstmid");

    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_cyc($urandom_range(0, 300));
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_frame(b, 1'b0);
    end
    rand_rdy = 1'b0;
    rd_ready = 1'b1;
    wait_cyc(30);
    compare_new("random");
    check_val("final ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check_val("final ovr", 32'(ovr_cnt), 32'(exp_ovr));
    check_val("final count", 32'(fifo_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front end for the board's uart_rx pin. It deserialises 8N1 frames and buffers the received bytes in a small FIFO. Bytes are presented to a downstream consumer (MCU input port logic or a debug loader) over a valid/ready interface. All logic runs on the 50 MHz board clock, not on the muxed MCU clock, so reception is unaffected by slow-clock debug mode.

Parameters:
CLK_FREQUENCY, 50000000, input clock frequency in Hz.
BAUD_RATE, 115200, serial bit rate.
FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  board clock.
reset_n  input  1  reset, asynchronous assert, active-low.
uart_rx  input  1  asynchronous serial line, idle high.
rd_data  output  8  byte at FIFO head; valid only while rd_valid=1.
rd_valid  output  1  FIFO non-empty.
rd_ready  input  1  consumer pop; a pop occurs when rd_valid & rd_ready at posedge clk.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
frame_err  output  1  one-cycle pulse when a frame's stop bit samples 0.
overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Clock and reset: one clock (clk). reset_n is asynchronous assert, active-low, and is the only reset.
- Reset values: rd_valid=0, rd_data=0, fifo_count=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1.
- Input synchronisation: uart_rx passes through a 2-flop synchroniser (rx_s). Total input latency is 2 cycles.
- Oversample tick:
  - DIV = CLK_FREQUENCY / (BAUD_RATE*16), integer truncation. Default is 27.
  - Tick counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - The counter is cleared on IDLE->START so sampling phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s=0, go to START.
  - START: after 8 ticks (mid start bit), sample rx_s. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: every 16 ticks, sample rx_s into shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after 16 ticks, sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Push/pop rules:
  - Push is a one-cycle strobe on the cycle the stop bit is accepted.
  - Push with FIFO not full: write at tail, fifo_count+1.
  - Push with FIFO full and no pop that cycle: byte dropped, overrun pulses, contents unchanged.
  - Push and pop in the same cycle: both happen, count unchanged. This includes the full case, so no overrun.
  - Pop with FIFO empty: ignored.
- Read side:
  - First-word fall-through: rd_data reflects the head combinationally from registered storage.
  - rd_valid rises the cycle after the push strobe.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. fifo_count saturates only by construction and never exceeds FIFO_DEPTH.
- Reset mid-frame: reset immediately returns the block to IDLE and empties the FIFO. A frame in progress on the line is lost. Its remaining low data bits may be seen as a new start; the resulting frame is either rejected or raises frame_err and is then recovered via BREAK.

Test Plan:
- Setup: CLK_FREQUENCY=1600000, BAUD_RATE=10000, so DIV=10 and one bit = 160 clocks. Consumer holds rd_ready=1 unless a scenario says otherwise.
- Single byte: send 0xA5 (8N1). rd_valid asserts once, rd_data=0xA5, fifo_count goes 0->1->0, and neither error pulse fires.
- Glitch: drive uart_rx low for 40 clocks, then high. FSM returns to IDLE with no push and no frame_err. A following 0x3C is received correctly.
- Framing error: send 0x55 with stop bit 0, hold the line low 500 clocks, then release and send 0x12. Expect exactly one frame_err pulse, no push for 0x55, then 0x12 received.
- Overrun: with rd_ready=0, send 9 bytes 0x01..0x09. fifo_count=8, overrun pulses once on byte 9. Then raise rd_ready and read 0x01..0x08 in order.
- Simultaneous full push/pop: with the FIFO full, pulse rd_ready on the exact push cycle of a new byte 0x77. Expect no overrun, count stays 8, and 0x77 is the last entry read.
- Reset mid-frame: assert reset_n low during bit 3 of a frame with 3 bytes queued. Immediately rd_valid=0 and fifo_count=0. After release and line idle for 160 clocks, 0xC3 is received correctly.
